// File: rtl/atb_trace_sink.sv
// atb_trace_sink: ATB sink with programmable backpressure, per-ID beat
// counters, an APB-readable capture FIFO and a flush handshake.
module atb_trace_sink #(
    parameter int DATA_LEN       = 32,
    parameter int NUM_IDS        = 4,
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_W          = 32,
    parameter int APB_ADDR_WIDTH = 32,
    localparam int BYTES_W       = $clog2(DATA_LEN) - 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      atvalid_i,
    input  logic [DATA_LEN-1:0]       atdata_i,
    input  logic [BYTES_W-1:0]        atbytes_i,
    input  logic [6:0]                atid_i,
    output logic                      atready_o,
    output logic                      afvalid_o,
    input  logic                      afready_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic [31:0]               pwdata_i,
    output logic                      pready_o,
    output logic [31:0]               prdata_o,
    output logic                      ovf_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_e;

    logic [7:0]          addr;
    logic                acc, wr, rd;
    logic                wr_ctrl, wr_pat, clr, flush_req;
    logic                en_q, sof_q, sof_d;
    logic [15:0]         on_q, off_q;
    logic [15:0]         phase_q, phase_d;
    state_e              state_q, state_d;
    logic                atready_q, afvalid_q, ovf_q;
    logic [6:0]          id_mem  [FIFO_DEPTH];
    logic [BYTES_W-1:0]  by_mem  [FIFO_DEPTH];
    logic [DATA_LEN-1:0] dat_mem [FIFO_DEPTH];
    logic [AW-1:0]       wp_q, rp_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                full, empty, beat, push, pop, ovf_set, id_known;
    logic [CNT_W-1:0]    beat_q, unk_q;
    logic [CNT_W-1:0]    idc_q [NUM_IDS];
    logic [31:0]         rdata;

    function automatic state_e start_state(input logic [15:0] on,
                                           input logic [15:0] off);
        return (on == '0 && off != '0) ? S_OFF : S_ON;
    endfunction

    if (APB_ADDR_WIDTH > 8) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^paddr_i[APB_ADDR_WIDTH-1:8];
    end

    assign addr      = paddr_i[7:0];
    assign acc       = psel_i & penable_i & ~rst_i;
    assign wr        = acc & pwrite_i;
    assign rd        = acc & ~pwrite_i;
    assign wr_ctrl   = wr && addr == 8'h00;
    assign wr_pat    = wr && addr == 8'h04;
    assign clr       = wr_ctrl & pwdata_i[3];
    assign flush_req = wr_ctrl & pwdata_i[1];
    assign sof_d     = wr_ctrl ? pwdata_i[2] : sof_q;

    assign full     = cnt_q == FULL_CNT;
    assign empty    = cnt_q == '0;
    assign beat     = atvalid_i & atready_q;
    assign pop      = rd && addr == 8'h18 && !empty;
    assign push     = beat && (!full || pop);
    assign ovf_set  = beat && full && !pop;
    assign id_known = {25'd0, atid_i} < 32'(NUM_IDS);

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    // Backpressure next-state: on/off phases counted in phase_q
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (!en_q) begin
            state_d = S_IDLE;
            phase_d = '0;
        end else if (wr_pat) begin
            state_d = start_state(pwdata_i[15:0], pwdata_i[31:16]);
            phase_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = start_state(on_q, off_q);
                    phase_d = '0;
                end
                S_ON: begin
                    if (off_q != '0) begin
                        if (on_q == '0 || phase_q == on_q - 16'd1) begin
                            state_d = S_OFF;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 16'd1;
                        end
                    end
                end
                S_OFF: begin
                    if (off_q == '0) begin
                        state_d = S_ON;
                        phase_d = '0;
                    end else if (on_q != '0) begin
                        if (phase_q == off_q - 16'd1) begin
                            state_d = S_ON;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    // Backpressure FSM with registered ready, held low when a stopping FIFO fills
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            atready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            atready_q <= (state_d == S_ON) && !(sof_d && cnt_d == FULL_CNT);
        end
    end

    // CTRL and PATTERN registers; flush and clr are pulses, not stored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q  <= 1'b0;
            sof_q <= 1'b0;
            on_q  <= '0;
            off_q <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q  <= pwdata_i[0];
                sof_q <= pwdata_i[2];
            end
            if (wr_pat) begin
                on_q  <= pwdata_i[15:0];
                off_q <= pwdata_i[31:16];
            end
        end
    end

    // Flush request held until the source acknowledges
    always_ff @(posedge clk_i) begin
        if (rst_i)
            afvalid_q <= 1'b0;
        else if (afvalid_q)
            afvalid_q <= !afready_i;
        else if (flush_req)
            afvalid_q <= 1'b1;
    end

    // Capture FIFO storage and pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                id_mem[wp_q]  <= atid_i;
                by_mem[wp_q]  <= atbytes_i;
                dat_mem[wp_q] <= atdata_i;
                wp_q          <= wp_q + AW'(1);
            end
            if (pop)
                rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Beat counters and sticky overflow; clr wins over a same-cycle beat
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            beat_q <= '0;
            unk_q  <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < NUM_IDS; i++)
                idc_q[i] <= '0;
        end else if (beat) begin
            beat_q <= beat_q + CNT_W'(1);
            if (!id_known)
                unk_q <= unk_q + CNT_W'(1);
            for (int i = 0; i < NUM_IDS; i++)
                if (atid_i == 7'(i))
                    idc_q[i] <= idc_q[i] + CNT_W'(1);
            if (ovf_set)
                ovf_q <= 1'b1;
        end
    end

    // APB read mux, zero outside a read access
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                8'h00: rdata = {29'd0, sof_q, 1'b0, en_q};
                8'h04: rdata = {off_q, on_q};
                8'h08: rdata = {14'd0, afvalid_q, ovf_q, 16'(cnt_q)};
                8'h0C: rdata = 32'(beat_q);
                8'h10: rdata = 32'(unk_q);
                8'h14: rdata = empty ? '0 :
                       {17'd0, 7'(by_mem[rp_q]), 1'b0, id_mem[rp_q]};
                8'h18: rdata = empty ? '0 : 32'(dat_mem[rp_q]);
                default: rdata = '0;
            endcase
            for (int i = 0; i < NUM_IDS; i++)
                if (addr == 8'(32 + 4 * i))
                    rdata = 32'(idc_q[i]);
        end
    end

    assign atready_o = atready_q;
    assign afvalid_o = afvalid_q;
    assign ovf_o     = ovf_q;
    assign pready_o  = acc;
    assign prdata_o  = rdata;

endmodule

// File: tb/tb_atb_trace_sink.sv
// tb_atb_trace_sink: directed, table-driven checks of the ATB trace sink:
// backpressure pattern, overflow, stop-on-full, IDs, flush and reset.
module tb_atb_trace_sink;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        atvalid_i = 1'b0;
    logic [31:0] atdata_i = '0;
    logic [1:0]  atbytes_i = '0;
    logic [6:0]  atid_i = '0;
    logic        atready_o;
    logic        afvalid_o;
    logic        afready_i = 1'b0;
    logic [31:0] paddr_i = '0;
    logic        pwrite_i = 1'b0;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic [31:0] pwdata_i = '0;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        ovf_o;

    atb_trace_sink dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .atvalid_i (atvalid_i),
        .atdata_i  (atdata_i),
        .atbytes_i (atbytes_i),
        .atid_i    (atid_i),
        .atready_o (atready_o),
        .afvalid_o (afvalid_o),
        .afready_i (afready_i),
        .paddr_i   (paddr_i),
        .pwrite_i  (pwrite_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwdata_i  (pwdata_i),
        .pready_o  (pready_o),
        .prdata_o  (prdata_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [6:0]  id;
        logic [1:0]  by;
        logic [31:0] data;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int pready_cnt = 0;

    rd_vec_t zero_tab [14];
    rd_vec_t id_tab [8];
    beat_t   beat_tab [3];

    always @(posedge clk_i)
        if (pready_o)
            pready_cnt <= pready_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge
    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
        paddr_i = {24'd0, a}; pwdata_i = d;
        @(negedge clk_i);
        penable_i = 1'b1;
        n_acc++;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = {24'd0, a};
        @(negedge clk_i);
        penable_i = 1'b1;
        n_acc++;
        #1;
        d = prdata_o;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] e);
        logic [31:0] v;
        apb_rd(a, v);
        chk($sformatf("reg_%02h", a), v, e);
    endtask

    task automatic send_beat(input logic [6:0] id, input logic [1:0] by,
                             input logic [31:0] d, input int budget,
                             output bit ok);
        atvalid_i = 1'b1; atid_i = id; atbytes_i = by; atdata_i = d;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (atready_o) begin
                ok = 1'b1;
                @(negedge clk_i);
                break;
            end
            @(negedge clk_i);
        end
        atvalid_i = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int t;
        t = 0;
        while (!atready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk(nm, {31'd0, atready_o}, 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; atvalid_i = 1'b0; afready_i = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        bit ok;
        int bad;

        zero_tab = '{'{8'h00, 0}, '{8'h04, 0}, '{8'h08, 0}, '{8'h0C, 0},
                     '{8'h10, 0}, '{8'h14, 0}, '{8'h18, 0}, '{8'h1C, 0},
                     '{8'h20, 0}, '{8'h24, 0}, '{8'h28, 0}, '{8'h2C, 0},
                     '{8'h30, 0}, '{8'hFC, 0}};
        beat_tab = '{'{7'd1, 2'd2, 32'h0000_0011},
                     '{7'd3, 2'd1, 32'h0000_0033},
                     '{7'd9, 2'd3, 32'h0000_0099}};
        id_tab = '{'{8'h20, 32'd0}, '{8'h24, 32'd1}, '{8'h28, 32'd0},
                   '{8'h2C, 32'd1}, '{8'h10, 32'd1}, '{8'h0C, 32'd3},
                   '{8'h08, 32'h0000_0003}, '{8'h14, 32'h0000_0201}};

        // Reset state
        @(negedge clk_i);
        do_reset();
        chk("rst_atready", {31'd0, atready_o}, 0);
        chk("rst_afvalid", {31'd0, afvalid_o}, 0);
        chk("rst_ovf", {31'd0, ovf_o}, 0);
        chk("rst_pready", {31'd0, pready_o}, 0);
        chk("idle_prdata", prdata_o, 0);
        foreach (zero_tab[i]) rd_chk(zero_tab[i].addr, zero_tab[i].exp);

        // 3-on / 2-off pattern with atvalid held on id 0
        apb_wr(8'h04, {16'd2, 16'd3});
        atvalid_i = 1'b1; atid_i = 7'd0; atdata_i = 32'hC0DE_0000;
        apb_wr(8'h00, 32'h1);
        wait_ready("pat_start");
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (atready_o !== ((k % 5) < 3)) bad++;
            @(negedge clk_i);
        end
        atvalid_i = 1'b0;
        chk("pattern_seq", bad, 0);
        apb_wr(8'h00, 32'h0);
        rd_chk(8'h0C, 32'd30);
        rd_chk(8'h20, 32'd30);
        rd_chk(8'h08, 32'h0001_0010);
        chk("pat_ovf_o", {31'd0, ovf_o}, 1);
        apb_wr(8'h00, 32'h8);
        rd_chk(8'h0C, 32'd0);
        rd_chk(8'h20, 32'd0);
        rd_chk(8'h08, 32'h0000_0010);
        chk("clr_ovf_o", {31'd0, ovf_o}, 0);

        // Overflow with stop_on_full=0
        do_reset();
        apb_wr(8'h04, 32'h0000_0001);
        apb_wr(8'h00, 32'h1);
        wait_ready("ovf_start");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            send_beat(7'd2, 2'd3, 32'hA000_0000 | i, 20, ok);
            if (!ok) bad++;
        end
        chk("ovf_sends", bad, 0);
        rd_chk(8'h08, 32'h0001_0010);
        chk("ovf_o", {31'd0, ovf_o}, 1);
        rd_chk(8'h0C, 32'd20);
        for (int i = 0; i < 16; i++) rd_chk(8'h18, 32'hA000_0000 | i);
        rd_chk(8'h18, 32'h0);
        rd_chk(8'h08, 32'h0001_0000);

        // stop_on_full=1: one pop admits exactly one beat
        do_reset();
        apb_wr(8'h04, 32'h0000_0001);
        apb_wr(8'h00, 32'h5);
        wait_ready("sof_start");
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            send_beat(7'd0, 2'd3, 32'hB000_0000 | i, 20, ok);
            if (!ok) bad++;
        end
        chk("sof_sends", bad, 0);
        chk("sof_ready_low", {31'd0, atready_o}, 0);
        send_beat(7'd0, 2'd3, 32'hB000_0010, 5, ok);
        chk("sof_blocked", {31'd0, ok}, 0);
        atvalid_i = 1'b1; atdata_i = 32'hB000_0010;
        rd_chk(8'h18, 32'hB000_0000);
        repeat (4) @(negedge clk_i);
        chk("sof_refull", {31'd0, atready_o}, 0);
        atvalid_i = 1'b0;
        rd_chk(8'h0C, 32'd17);
        rd_chk(8'h08, 32'h0000_0010);
        chk("sof_ovf_o", {31'd0, ovf_o}, 0);
        rd_chk(8'h18, 32'hB000_0001);

        // Per-ID counters and FIFO metadata
        do_reset();
        apb_wr(8'h04, 32'h0000_0001);
        apb_wr(8'h00, 32'h1);
        wait_ready("id_start");
        bad = 0;
        foreach (beat_tab[i]) begin
            send_beat(beat_tab[i].id, beat_tab[i].by, beat_tab[i].data, 20, ok);
            if (!ok) bad++;
        end
        chk("id_sends", bad, 0);
        foreach (id_tab[i]) rd_chk(id_tab[i].addr, id_tab[i].exp);
        rd_chk(8'h18, 32'h0000_0011);
        rd_chk(8'h14, 32'h0000_0103);

        // Flush handshake, with a second flush write while busy
        do_reset();
        apb_wr(8'h00, 32'h3);
        chk("fl_set", {31'd0, afvalid_o}, 1);
        rd_chk(8'h08, 32'h0002_0000);
        apb_wr(8'h00, 32'h3);
        chk("fl_hold", {31'd0, afvalid_o}, 1);
        afready_i = 1'b1;
        @(negedge clk_i);
        afready_i = 1'b0;
        chk("fl_drop", {31'd0, afvalid_o}, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (afvalid_o) bad++;
        end
        chk("fl_no_requeue", bad, 0);
        rd_chk(8'h08, 32'h0000_0000);

        // Reset mid-burst with 5 entries stored and a flush pending
        do_reset();
        apb_wr(8'h04, 32'h0000_0001);
        apb_wr(8'h00, 32'h1);
        wait_ready("mid_start");
        for (int i = 0; i < 5; i++)
            send_beat(7'd1, 2'd0, 32'hD000_0000 | i, 20, ok);
        rd_chk(8'h08, 32'h0000_0005);
        apb_wr(8'h00, 32'h3);
        atvalid_i = 1'b1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_atready", {31'd0, atready_o}, 0);
        chk("mid_afvalid", {31'd0, afvalid_o}, 0);
        chk("mid_ovf", {31'd0, ovf_o}, 0);
        chk("mid_prdata", prdata_o, 0);
        atvalid_i = 1'b0;
        rst_i = 1'b0;
        foreach (zero_tab[i]) rd_chk(zero_tab[i].addr, zero_tab[i].exp);

        @(negedge clk_i);
        chk("pready_pulses", pready_cnt, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/atb_trace_sink.md
Name: atb_trace_sink

Overview:
- Synthesizable ATB trace sink that terminates the trace encapsulator's ATB output.
- Generalises the fixed 3-on/2-off bench sink:
  - programmable backpressure pattern
  - per-ID beat counters
  - capture FIFO readable over APB
  - software-triggered flush handshake on afvalid/afready
- Used in simulation benches and FPGA bring-up of the tracer subsystem.

Parameters:
- DATA_LEN, 32, ATB data width in bits (multiple of 8, ≤ 64).
- NUM_IDS, 4, number of ATB IDs (0..NUM_IDS-1) with a dedicated beat counter.
- FIFO_DEPTH, 16, capture FIFO entries; power of two.
- CNT_W, 32, counter width; wraps modulo 2^CNT_W.
- APB_ADDR_WIDTH, 32, APB address width; decode uses paddr_i[7:0].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- atvalid_i  in  1  ATB beat valid.
- atdata_i  in  DATA_LEN  ATB data.
- atbytes_i  in  $clog2(DATA_LEN)-3  ATB bytes field, value = valid bytes - 1.
- atid_i  in  7  ATB trace ID.
- atready_o  out  1  ATB ready; registered.
- afvalid_o  out  1  flush request to the source.
- afready_i  in  1  flush complete from the source.
- paddr_i  in  APB_ADDR_WIDTH  APB address.
- pwrite_i, psel_i, penable_i  in  1 each  APB controls.
- pwdata_i  in  32  APB write data.
- pready_o  out  1  APB ready.
- prdata_o  out  32  APB read data.
- ovf_o  out  1  sticky overflow flag, mirrors STATUS.ovf.

Behaviour:
- Reset: every register and output is 0. This includes atready_o, afvalid_o, pready_o, prdata_o, ovf_o, the FIFO pointers and count, all counters, CTRL and PATTERN. Reset mid-transfer discards FIFO contents and aborts any flush.
- Register map (offsets on paddr_i[7:0]):
  - 0x00 CTRL: bit0 en; bit1 flush (W1, self-clears); bit2 stop_on_full; bit3 clr (W1, self-clears).
  - 0x04 PATTERN: [15:0] on_cycles; [31:16] off_cycles.
  - 0x08 STATUS: RO; [15:0] fifo_count; bit16 ovf; bit17 flush_busy.
  - 0x0C BEAT_CNT: RO.
  - 0x10 UNK_CNT: RO; beats with atid_i ≥ NUM_IDS.
  - 0x14 FIFO_META: RO peek of head entry; [6:0] id; [14:8] bytes.
  - 0x18 FIFO_DATA: RO; read of the head entry's low 32 data bits pops the entry.
  - 0x20+4i ID_CNT[i]: RO.
  - Unmapped addresses read 0; writes to them and to RO registers are ignored.
- APB: zero wait states.
  - pready_o = psel_i & penable_i, combinational, 1-cycle pulse per access.
  - prdata_o is valid in the access cycle; it is 0 outside access.
  - Writes take effect at the clock edge that ends the access cycle.
- Backpressure state machine, states IDLE/ON/OFF, with a 16-bit phase counter:
  - IDLE: atready_o = 0. On en=1 go to ON with counter = 0.
  - ON: atready_o = 1 (registered, so visible 1 cycle after entry). After on_cycles cycles go to OFF, counter = 0.
  - OFF: atready_o = 0. After off_cycles cycles go to ON.
  - off_cycles = 0: stay in ON permanently.
  - on_cycles = 0 with off_cycles ≠ 0: stay in OFF permanently.
  - en=0 from any state: return to IDLE next cycle.
  - A PATTERN write restarts the machine in ON.
- Final ready: atready_o is additionally forced to 0 when stop_on_full=1 and the FIFO is full (fifo_count = FIFO_DEPTH).
- Beat acceptance: a beat is accepted when atvalid_i & atready_o at the clock edge.
  - Accepted beat increments BEAT_CNT and either ID_CNT[atid_i] or UNK_CNT.
  - If the FIFO is not full, push {atid_i, atbytes_i, atdata_i}.
  - If the FIFO is full (only possible with stop_on_full=0): the beat is counted but not stored, and ovf is set (sticky).
- Simultaneous push and pop in one cycle: both occur and fifo_count is unchanged. At full with a pop in the same cycle, the push succeeds and ovf is not set.
- FIFO_DATA read when empty returns 0 and does not pop. FIFO_META when empty reads 0.
- clr: zeroes all counters and ovf in one cycle; FIFO untouched. A beat accepted in the clr cycle is not counted.
- Flush:
  - Writing CTRL.flush=1 sets afvalid_o on the next cycle.
  - afvalid_o is held until afready_i is sampled 1; afvalid_o drops the cycle after.
  - flush_busy = afvalid_o.
  - A flush write while busy is ignored.
  - Beats continue to be accepted during a flush.
- All counters wrap silently at 2^CNT_W.

Test Plan:
- PATTERN on=3 off=2, en=1, atvalid_i held with id 0: atready_o repeats 1,1,1,0,0; after 50 cycles BEAT_CNT=30 and ID_CNT[0]=30.
- 20 beats, stop_on_full=0, FIFO_DEPTH=16, off=0, no reads: fifo_count=16, ovf=1, ovf_o=1, BEAT_CNT=20. FIFO_DATA reads return beats 0..15 in order; the 17th read returns 0.
- stop_on_full=1, same stimulus: atready_o=0 after the 16th beat, ovf=0. One FIFO_DATA pop re-enables exactly one beat.
- Beats with ids 1, 3 and 9 (NUM_IDS=4): ID_CNT[1]=1, ID_CNT[3]=1, UNK_CNT=1. FIFO_META of the first entry shows id=1 and the written bytes value.
- Write CTRL=0x3: afvalid_o=1 from the next cycle; afready_i pulsed 4 cycles later; afvalid_o=0 the cycle after; STATUS bit17 tracks it.
- Assert rst_i mid-burst with fifo_count=5: all outputs are 0 and all registers read 0 the next cycle; APB pready_o pulses exactly once per access.
